uart_rx_periph: RTL

- Memory-mapped UART receiver, the receive-side counterpart of the existing UART TX peripheral.
- Sits behind the peripheral controller at periph slot 4'h5 (PERIPH_BASE_ADDR + 0x500).
- Deserialises 8N1 frames from the rx pin and buffers bytes in a small FIFO.
- Exposes DATA/CTRL/STATUS registers through the standard pctrl register port and raises a level interrupt toward the interrupt controller.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/uart_rx_periph.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART register map, bit positions and receiver FSM encoding
//
// Contents:
//   PERIPH_BASE_ADDR / UART_RX_ADDR : system address of the receiver (periph slot 4'h5)
//   UART_RX_DATA/CTRL/STATUS        : register indices as seen on reg_addr
//   CTRL_* / STAT_*                 : bit positions inside CTRL and STATUS
//   ST_*                            : receiver FSM state encoding
//   expected_parity()               : parity bit a transmitter would send for a byte
package uart_pkg;

    localparam logic [31:0] PERIPH_BASE_ADDR = 32'h4000_0000;
    localparam logic [31:0] UART_RX_ADDR     = PERIPH_BASE_ADDR + 32'h0000_0500;

    localparam logic [3:0] UART_RX_DATA   = 4'h0;
    localparam logic [3:0] UART_RX_CTRL   = 4'h1;
    localparam logic [3:0] UART_RX_STATUS = 4'h2;

    localparam int CTRL_RXEN = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEN  = 2;
    localparam int CTRL_ODD  = 3;

    localparam int STAT_AVAIL   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_FERR    = 3;
    localparam int STAT_PERR    = 4;
    localparam int STAT_OCC_LSB = 5;
    localparam int STAT_OCC_MSB = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even parity: bit makes the total count of ones even; odd parity inverts it.
    function automatic logic expected_parity(input logic [7:0] d, input logic odd);
        return odd ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised synchronous FIFO with push/pop/full/empty/count
//
// Parameters: WIDTH entry width, DEPTH entry count (power of two, >= 2)
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write request; accepted when not full, or when full with a pop in the same cycle
//   pop, pop_data      read request; ignored when empty; pop_data shows the head entry
//   full, empty, count status; count is the current occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_periph.sv
// rtl/uart_rx_periph.sv - memory-mapped 8N1 UART receiver with receive FIFO and level interrupt
//
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, CTRL PEN/ODD, STATUS PERR)
// Parameters: CLKS_PER_BIT (>= 4), FIFO_DEPTH (power of two, 2..16), DATA_WIDTH (>= 9)
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   ce, rw             one-cycle register access strobe, 1 = write / 0 = read
//   reg_addr           register index: 0 DATA, 1 CTRL, 2 STATUS
//   data_in, data_out  write data, combinational read data
//   rx                 asynchronous serial input, idle high
//   rx_intr            registered level interrupt
module uart_rx_periph #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  rw,
    input  logic [3:0]            reg_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rx,
    output logic                  rx_intr
);
    import uart_pkg::*;

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int              OCC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             brk_q, brk_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             intr_q, intr_d;

    logic             rx_s;
    logic             pen;
    logic             fsm_push;
    logic             ferr_set;
    logic             perr_set;
    logic             ovr_set;
    logic             wr_en;
    logic             rd_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    logic [4:0]       occ_ext;
    logic             unused_ok;

    assign rx_s = rx_s_q;

`ifdef UART_RX_PARITY_EN
    assign pen = ctrl_q[CTRL_PEN];
`else
    assign pen = 1'b0;
`endif

    // ---------------- register interface ----------------
    assign wr_en  = ce && rw;
    assign rd_pop = ce && !rw && (reg_addr == UART_RX_DATA) && !fifo_empty;

    // A push that finds the FIFO full is dropped unless a pop frees a slot this cycle.
    assign ovr_set = fsm_push && fifo_full && !rd_pop;

    always_comb begin
        ctrl_d = ctrl_q;
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        perr_d = perr_q;
        if (wr_en && (reg_addr == UART_RX_CTRL)) begin
`ifdef UART_RX_PARITY_EN
            ctrl_d = data_in[3:0];
`else
            ctrl_d = {2'b00, data_in[1:0]};
`endif
        end
        if (wr_en && (reg_addr == UART_RX_STATUS)) begin
            if (data_in[STAT_OVR])  ovr_d  = 1'b0;
            if (data_in[STAT_FERR]) ferr_d = 1'b0;
            if (data_in[STAT_PERR]) perr_d = 1'b0;
        end
        // Set after clear so a new event in the clear cycle is not lost.
        if (ovr_set)  ovr_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
        if (perr_set) perr_d = 1'b1;
    end

    assign intr_d = ctrl_q[CTRL_IE] && (!fifo_empty || ovr_q || ferr_q || perr_q);
    assign rx_intr = intr_q;

    // Occupancy field is four bits; a 16-deep FIFO reads 0 when full (FULL tells them apart).
    assign occ_ext = 5'(fifo_count);

    always_comb begin
        data_out = '0;
        case (reg_addr)
            UART_RX_DATA: begin
                if (!fifo_empty) data_out[7:0] = fifo_head;
            end
            UART_RX_CTRL: begin
                data_out[3:0] = ctrl_q;
            end
            UART_RX_STATUS: begin
                data_out[STAT_AVAIL]                 = !fifo_empty;
                data_out[STAT_FULL]                  = fifo_full;
                data_out[STAT_OVR]                   = ovr_q;
                data_out[STAT_FERR]                  = ferr_q;
                data_out[STAT_PERR]                  = perr_q;
                data_out[STAT_OCC_MSB:STAT_OCC_LSB]  = occ_ext[3:0];
            end
            default: data_out = '0;
        endcase
    end

    // ---------------- receive FSM ----------------
    assign rx_meta_d = rx;
    assign rx_s_d    = rx_meta_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        fsm_push  = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        if (!ctrl_q[CTRL_RXEN]) begin
            // Disabled: hold or abort to IDLE silently; FIFO and flags untouched.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    // After a framing error the line may sit low (break); wait for it to
                    // go high before looking for the next start edge.
                    if (brk_q) begin
                        if (rx_s) brk_d = 1'b0;
                    end else if (!rx_s) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = pen ? ST_PARITY : ST_STOP;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        perr_set = (rx_s != expected_parity(shift_q, ctrl_q[CTRL_ODD]));
                        state_d  = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        if (rx_s) begin
                            fsm_push = 1'b1;
                        end else begin
                            ferr_set = 1'b1;
                            brk_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (fsm_push),
        .push_data (shift_q),
        .pop       (rd_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            brk_q     <= 1'b0;
            ctrl_q    <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            brk_q     <= brk_d;
            ctrl_q    <= ctrl_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            intr_q    <= intr_d;
        end
    end

    assign unused_ok = ^{data_in, occ_ext[4]};

endmodule
